// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU and the ALU control decoder.
// Holds the 3-bit ALU control codes, the default datapath width and the
// IDLE/BUSY state encoding used by ex_alu_unit.
package alu_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned RD_W     = 5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_MUL = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_SRA = 3'b101;
    localparam logic [2:0] ALU_AND = 3'b110;
    localparam logic [2:0] ALU_ILL = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier retiring MUL_STEP multiplier bits per cycle.
// The first step is taken in the start cycle straight from the operand inputs,
// so an N-step multiply reports done in its N-th active cycle.
// Optional feature macro: MUL_EARLY_TERM_EN -- finish as soon as no set
// multiplier bits remain after the current step.
// Ports:
//   clk_i, rst_i  clock, async active-low reset
//   i_start       operands on i_a/i_b are accepted this cycle
//   i_busy        a multiply is in flight (continue stepping)
//   i_flush       abandon the current multiply
//   i_a, i_b      multiplicand, multiplier
//   o_done_c      final step happens this cycle, o_prod_c is the result
//   o_early_c     done this cycle ahead of the full step count
//   o_prod_c      accumulator including this cycle's partial product
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned MUL_STEP = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            i_start,
    input  logic            i_busy,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_done_c,
    output logic            o_early_c,
    output logic [XLEN-1:0] o_prod_c
);

    localparam int unsigned N     = XLEN / MUL_STEP;
    localparam int unsigned CNT_W = $clog2(N) + 1;

    logic [XLEN-1:0]  r_mcand;
    logic [XLEN-1:0]  r_mplier;
    logic [XLEN-1:0]  r_acc;
    logic [CNT_W-1:0] r_cnt;

    logic [XLEN-1:0]  w_mcand;
    logic [XLEN-1:0]  w_mplier;
    logic [XLEN-1:0]  w_acc;
    logic [XLEN-1:0]  w_part;
    logic [XLEN-1:0]  w_rest;
    logic [CNT_W-1:0] w_cnt;
    logic             w_active;
    logic             w_last;

    // Current step operands: fresh inputs on start, otherwise the shifted registers.
    always_comb begin
        w_mcand  = i_start ? i_a : r_mcand;
        w_mplier = i_start ? i_b : r_mplier;
        w_acc    = i_start ? '0  : r_acc;
        w_cnt    = i_start ? '0  : r_cnt;
        w_part   = '0;
        for (int unsigned j = 0; j < MUL_STEP; j++) begin
            if (|(w_mplier & (XLEN'(1) << j))) begin
                w_part = w_part + (w_mcand << j);
            end
        end
        w_rest   = w_mplier >> MUL_STEP;
        w_active = (i_start || i_busy) && !i_flush;
        w_last   = (w_cnt == CNT_W'(N - 1));
        o_prod_c = w_acc + w_part;
`ifdef MUL_EARLY_TERM_EN
        o_early_c = w_active && (w_rest == '0) && !w_last;
`else
        o_early_c = 1'b0;
`endif
        o_done_c = w_active && (w_last || o_early_c);
    end

    // Step registers; a flushed multiply simply stops, start reloads everything.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (w_active) begin
            r_mcand  <= w_mcand << MUL_STEP;
            r_mplier <= w_rest;
            r_acc    <= o_prod_c;
            r_cnt    <= w_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ex_alu_unit.sv
// Execute-stage ALU: single-cycle add/sub/xor/sll/sra/and into registered
// outputs, multi-cycle MUL through alu_mul_iter with upstream stall.
// Optional feature macro: MUL_EARLY_TERM_EN (handled inside alu_mul_iter).
// Ports:
//   clk_i, rst_i      clock, async active-low reset
//   flush_i           squash the op being accepted and any in-flight MUL
//   valid_i           op present on ALUCtrl_i/data1_i/data2_i/rd_i
//   ALUCtrl_i         3-bit ALU control code (alu_pkg::ALU_*)
//   data1_i, data2_i  operands A and B
//   rd_i              destination tag
//   valid_o           one-cycle result pulse
//   result_o, rd_o    registered result and destination tag
//   zero_o            registered (result == 0)
//   stall_o           combinational hold request to the ID/EX register
module ex_alu_unit
    import alu_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned MUL_STEP = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            valid_i,
    input  logic [2:0]      ALUCtrl_i,
    input  logic [XLEN-1:0] data1_i,
    input  logic [XLEN-1:0] data2_i,
    input  logic [RD_W-1:0] rd_i,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic [RD_W-1:0] rd_o,
    output logic            zero_o,
    output logic            stall_o
);

    localparam int unsigned SH_W = $clog2(XLEN);

    alu_state_e      r_state;
    alu_state_e      w_state_nxt;
    logic            r_valid;
    logic [XLEN-1:0] r_result;
    logic [RD_W-1:0] r_rd;
    logic            r_zero;
    logic [RD_W-1:0] r_mul_rd;

    logic [SH_W-1:0] w_shamt;
    logic [XLEN-1:0] w_alu_res;
    logic            w_load;
    logic [XLEN-1:0] w_load_val;
    logic [RD_W-1:0] w_load_rd;
    logic            w_mul_start;
    logic            w_mul_busy;
    logic            w_mul_done;
    logic            w_mul_early;
    logic [XLEN-1:0] w_mul_prod;

    assign w_shamt     = data2_i[SH_W-1:0];
    assign w_mul_start = (r_state == ST_IDLE) && valid_i && !flush_i && (ALUCtrl_i == ALU_MUL);
    assign w_mul_busy  = (r_state == ST_BUSY);

    alu_mul_iter #(
        .XLEN     (XLEN),
        .MUL_STEP (MUL_STEP)
    ) u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_start   (w_mul_start),
        .i_busy    (w_mul_busy),
        .i_flush   (flush_i),
        .i_a       (data1_i),
        .i_b       (data2_i),
        .o_done_c  (w_mul_done),
        .o_early_c (w_mul_early),
        .o_prod_c  (w_mul_prod)
    );

    // Single-cycle datapath; MUL and the illegal code both yield zero here.
    always_comb begin
        w_alu_res = '0;
        case (ALUCtrl_i)
            ALU_ADD: w_alu_res = data1_i + data2_i;
            ALU_SUB: w_alu_res = data1_i - data2_i;
            ALU_XOR: w_alu_res = data1_i ^ data2_i;
            ALU_SLL: w_alu_res = data1_i << w_shamt;
            ALU_SRA: w_alu_res = XLEN'($signed(data1_i) >>> w_shamt);
            ALU_AND: w_alu_res = data1_i & data2_i;
            default: w_alu_res = '0;
        endcase
    end

    // Next state, stall and output-register load selection.
    always_comb begin
        w_state_nxt = r_state;
        stall_o     = 1'b0;
        w_load      = 1'b0;
        w_load_val  = w_alu_res;
        w_load_rd   = rd_i;
        case (r_state)
            ST_IDLE: begin
                if (valid_i && !flush_i) begin
                    if (ALUCtrl_i == ALU_MUL) begin
                        stall_o = 1'b1;
                        if (w_mul_done) begin
                            w_load     = 1'b1;
                            w_load_val = w_mul_prod;
                        end else begin
                            w_state_nxt = ST_BUSY;
                        end
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (flush_i) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    // An early finish releases upstream in the completing cycle.
                    stall_o = !w_mul_early;
                    if (w_mul_done) begin
                        w_load      = 1'b1;
                        w_load_val  = w_mul_prod;
                        w_load_rd   = r_mul_rd;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output registers hold their value between results.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_rd     <= '0;
            r_zero   <= 1'b0;
            r_mul_rd <= '0;
        end else begin
            r_valid <= w_load;
            if (w_load) begin
                r_result <= w_load_val;
                r_rd     <= w_load_rd;
                r_zero   <= (w_load_val == '0);
            end
            if (w_mul_start) begin
                r_mul_rd <= rd_i;
            end
        end
    end

    assign valid_o  = r_valid;
    assign result_o = r_result;
    assign rd_o     = r_rd;
    assign zero_o   = r_zero;

endmodule

// File: tb/tb_ex_alu_unit.sv
// Self-checking bench for ex_alu_unit: directed stimulus with a scoreboard of
// expected results (value, tag, zero flag, arrival edge). A second instance
// with MUL_STEP=4 shares the inputs to cover the faster multiply latency.
module tb_ex_alu_unit;
    import alu_pkg::*;

    localparam int STEP_A = 1;
    localparam int STEP_B = 4;
    localparam int N_A    = 32 / STEP_A;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        zero;
        int          edge_no;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        valid_i = 1'b0;
    logic [2:0]  ALUCtrl_i = 3'b000;
    logic [31:0] data1_i = '0;
    logic [31:0] data2_i = '0;
    logic [4:0]  rd_i = '0;
    logic        valid_o, zero_o, stall_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;
    logic        valid4, zero4, stall4;
    logic [31:0] result4;
    logic [4:0]  rd4;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_mis = 0;
    int          edge_cnt = 0;
    int          last_accept = 0;
    bit          v4_arm = 1'b0;
    bit          v4_seen = 1'b0;
    int          v4_edge = 0;
    logic [31:0] v4_res = '0;

    ex_alu_unit #(.XLEN(32), .MUL_STEP(STEP_A)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
        .ALUCtrl_i(ALUCtrl_i), .data1_i(data1_i), .data2_i(data2_i), .rd_i(rd_i),
        .valid_o(valid_o), .result_o(result_o), .rd_o(rd_o), .zero_o(zero_o),
        .stall_o(stall_o)
    );

    ex_alu_unit #(.XLEN(32), .MUL_STEP(STEP_B)) u_dut4 (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
        .ALUCtrl_i(ALUCtrl_i), .data1_i(data1_i), .data2_i(data2_i), .rd_i(rd_i),
        .valid_o(valid4), .result_o(result4), .rd_o(rd4), .zero_o(zero4),
        .stall_o(stall4)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] r;
        case (op)
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_MUL: r = a * b;
            ALU_XOR: r = a ^ b;
            ALU_SLL: r = a << b[4:0];
            ALU_SRA: r = $signed(a) >>> b[4:0];
            ALU_AND: r = a & b;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Cycles from acceptance (T) to valid_o (T+lat).
    function automatic int mul_lat(input logic [31:0] b, input int step);
        int s;
`ifdef MUL_EARLY_TERM_EN
        int bl;
        bl = 0;
        for (int i = 0; i < 32; i++) begin
            if (((b >> i) & 32'd1) != 32'd0) bl = i + 1;
        end
        s = (bl + step - 1) / step;
        if (s < 1) s = 1;
`else
        s = 32 / step;
`endif
        return s;
    endfunction

    // Scoreboard consumer, sampled 1 time unit after each rising edge.
    always @(posedge clk_i) begin
        #1;
        if (valid_o === 1'b1) begin
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_mis++;
                $error("FAIL unexpected_valid: observed valid_o=1 at edge %0d expected none", edge_cnt);
            end
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk({mon_e.tag, "_result"}, result_o, mon_e.res);
                chk({mon_e.tag, "_rd"}, 32'(rd_o), 32'(mon_e.rd));
                chk({mon_e.tag, "_zero"}, 32'(zero_o), 32'(mon_e.zero));
                chk({mon_e.tag, "_edge"}, 32'(edge_cnt), 32'(mon_e.edge_no));
            end
        end
        if (v4_arm && valid4 === 1'b1) begin
            v4_edge = edge_cnt;
            v4_res  = result4;
            v4_seen = 1'b1;
            v4_arm  = 1'b0;
        end
    end

    task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic flush, input logic push);
        logic [31:0] res;
        int lat;
        @(negedge clk_i);
        valid_i   = 1'b1;
        flush_i   = flush;
        ALUCtrl_i = op;
        data1_i   = a;
        data2_i   = b;
        rd_i      = rd;
        last_accept = edge_cnt + 1;
        if (push) begin
            res = model(op, a, b);
            lat = (op == ALU_MUL) ? mul_lat(b, STEP_A) : 1;
            sb.push_back('{tag, res, rd, (res == 32'd0), edge_cnt + lat});
        end
        #1 chk({tag, "_stall_t0"}, 32'(stall_o), (op == ALU_MUL && !flush) ? 32'd1 : 32'd0);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        flush_i = 1'b0;
    endtask

    // Issue a MUL and check stall in every cycle up to the completing one.
    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd);
        int lat;
        logic [31:0] exp_st;
        issue(tag, ALU_MUL, a, b, rd, 1'b0, 1'b1);
        lat = mul_lat(b, STEP_A);
        for (int k = 1; k < lat; k++) begin
            @(negedge clk_i);
            #1;
            exp_st = (k == lat - 1 && lat < N_A) ? 32'd0 : 32'd1;
            chk($sformatf("%s_stall_t%0d", tag, k), 32'(stall_o), exp_st);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: observed no end of stimulus by 50000 expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2 rst_i = 1'b0;
        #1;
        chk("reset_valid", 32'(valid_o), 32'd0);
        chk("reset_result", result_o, 32'd0);
        chk("reset_rd", 32'(rd_o), 32'd0);
        chk("reset_zero", 32'(zero_o), 32'd0);
        chk("reset_stall", 32'(stall_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;

        issue("add_5_7", ALU_ADD, 32'd5, 32'd7, 5'd3, 1'b0, 1'b1);
        issue("sub_9_9", ALU_SUB, 32'd9, 32'd9, 5'd4, 1'b0, 1'b1);
        issue("sra_neg", ALU_SRA, 32'h8000_0000, 32'd4, 5'd5, 1'b0, 1'b1);
        issue("sll_33", ALU_SLL, 32'd1, 32'd33, 5'd6, 1'b0, 1'b1);
        issue("xor", ALU_XOR, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd7, 1'b0, 1'b1);
        issue("and", ALU_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd8, 1'b0, 1'b1);
        issue("sub_wrap", ALU_SUB, 32'd0, 32'd1, 5'd9, 1'b0, 1'b1);
        issue("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'd1, 5'd10, 1'b0, 1'b1);
        issue("illegal", ALU_ILL, 32'd5, 32'd6, 5'd11, 1'b0, 1'b1);

        @(negedge clk_i);
        v4_arm = 1'b1;
        run_mul("mul_6_7", 32'd6, 32'd7, 5'd12);
        chk("mul4_seen", 32'(v4_seen), 32'd1);
        chk("mul4_edge", 32'(v4_edge), 32'(last_accept + mul_lat(32'd7, STEP_B) - 1));
        chk("mul4_result", v4_res, 32'd42);

        run_mul("mul_ffff_2", 32'hFFFF_FFFF, 32'd2, 5'd13);
        issue("add_at_tn", ALU_ADD, 32'd100, 32'd23, 5'd14, 1'b0, 1'b1);
        run_mul("mul_6_0", 32'd6, 32'd0, 5'd15);

        issue("flush_idle", ALU_ADD, 32'd1, 32'd2, 5'd16, 1'b1, 1'b0);

        issue("mul_flush", ALU_MUL, 32'd3, 32'hFFFF_0000, 5'd19, 1'b0, 1'b0);
        repeat (4) @(negedge clk_i);
        #1 chk("mul_flush_stall_t4", 32'(stall_o), 32'd1);
        @(negedge clk_i);
        flush_i = 1'b1;
        #1 chk("mul_flush_stall_t5", 32'(stall_o), 32'd0);
        @(posedge clk_i);
        #1 flush_i = 1'b0;
        issue("add_after_flush", ALU_ADD, 32'd20, 32'd3, 5'd17, 1'b0, 1'b1);

        issue("mul_reset", ALU_MUL, 32'd3, 32'hFFFF_0000, 5'd20, 1'b0, 1'b0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("midmul_rst_valid", 32'(valid_o), 32'd0);
        chk("midmul_rst_result", result_o, 32'd0);
        chk("midmul_rst_rd", 32'(rd_o), 32'd0);
        chk("midmul_rst_zero", 32'(zero_o), 32'd0);
        chk("midmul_rst_stall", 32'(stall_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;

        run_mul("mul_3_5", 32'd3, 32'd5, 5'd18);
        issue("add_last", ALU_ADD, 32'd1, 32'd1, 5'd21, 1'b0, 1'b1);

        repeat (40) @(posedge clk_i);
        #2 chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
